// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared FSM state type, default parameters and index-width helper
// for tx_arbiter and its round-robin picker.
package tx_arb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, DONE} state_t;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; the search starts at ptr_i and
// wraps, returning a one-hot grant, the winner index and an any-request flag.
module rr_pick
    import tx_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic [IW-1:0] j;
    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (req_i[j]) begin
                idx_o = j;
                gnt_o = N'(1) << j;
            end
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin sharing of one byte serializer between NUM_REQ producers.
// Define ARB_TIMEOUT_EN to abort a grant whose serializer never raises busy.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic                          TX_BUSY,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_VLD,
    output logic [NUM_REQ-1:0]            GRANT,
    output logic [NUM_REQ-1:0]            ACK,
    output logic                          ERR
);
    localparam int IW = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("tx_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("tx_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d, ack_q, ack_d, pick_gnt;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [IW-1:0]          ptr_q, ptr_d, idx_q, idx_d, pick_idx, next_ptr;
    logic                   vld_q, vld_d, busy_q, pick_any;
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d;
`endif

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req_i (REQ),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign next_ptr = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        vld_d   = 1'b0;
        ack_d   = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: if (pick_any && !TX_BUSY) begin
                grant_d = pick_gnt;
                data_d  = DATA_WIDTH'(REQ_DATA >> (int'(pick_idx) * DATA_WIDTH));
                idx_d   = pick_idx;
                vld_d   = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TX_BUSY) state_d = WAIT_DONE;
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else cnt_d = cnt_q + 1'b1;
`endif
            end
            WAIT_DONE: if (busy_q && !TX_BUSY) begin
                ack_d   = grant_q;
                state_d = DONE;
            end
            // Extra cycle keeps IDLE from sampling a REQ the owner drops in its ACK cycle.
            DONE: begin
                grant_d = '0;
                ptr_d   = next_ptr;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            busy_q  <= TX_BUSY;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign TX_DATA = data_q;
    assign TX_VLD  = vld_q;
    assign GRANT   = grant_q;
    assign ACK     = ack_q;
`ifdef ARB_TIMEOUT_EN
    assign ERR     = err_q;
`else
    assign ERR     = 1'b0;
`endif
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed self-checking bench for tx_arbiter (NUM_REQ=4, 8-bit data);
// the timeout scenario is selected by ARB_TIMEOUT_EN, matching the RTL build.
module tb_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        err;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .CLK      (clk),
        .RST      (rst_n),
        .REQ      (req),
        .REQ_DATA (req_data),
        .TX_BUSY  (tx_busy),
        .TX_DATA  (tx_data),
        .TX_VLD   (tx_vld),
        .GRANT    (grant),
        .ACK      (ack),
        .ERR      (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'(1 << i);
    endfunction

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[i*8 +: 8] = b;
    endtask

    task automatic grant_wait(input int idx, input logic [7:0] d, input int exp_wait);
        int t = 0;
        while (!tx_vld && t < 20) begin
            tick();
            t++;
        end
        check("grant_wait", t, exp_wait);
        check("vld", tx_vld, 1);
        check("grant", grant, oh(idx));
        check("tx_data", tx_data, d);
    endtask

    task automatic serve(input int idx, input logic [7:0] d, input int blen, input bit keep, input bit mess);
        int bad = 0;
        if (mess) begin
            req[idx] = 1'b0;
            req_data = '1;
        end
        tick();
        check("vld_pulse", tx_vld, 0);
        tx_busy = 1'b1;
        repeat (blen) begin
            tick();
            if (grant !== oh(idx) || ack !== 4'b0 || tx_data !== d) bad++;
        end
        check("hold", bad, 0);
        tx_busy = 1'b0;
        tick();
        check("ack", ack, oh(idx));
        check("ack_grant", grant, oh(idx));
        check("ack_data", tx_data, d);
        if (!keep) req[idx] = 1'b0;
        tick();
        check("ack_clr", ack, 0);
        check("grant_clr", grant, 0);
        check("err_idle", err, 0);
    endtask

    initial begin
        int bad;
        tick();
        check("rst_grant", grant, 0);
        check("rst_vld", tx_vld, 0);
        check("rst_ack", ack, 0);
        check("rst_data", tx_data, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // all requesters held: 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_byte(i, 8'(8'h10 + i));
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            grant_wait(r % 4, 8'(8'h10 + r % 4), 1);
            serve(r % 4, 8'(8'h10 + r % 4), 2, 1, 0);
        end
        req = '0;

        // single request, 10-cycle busy
        set_byte(0, 8'hA5);
        req = 4'b0001;
        grant_wait(0, 8'hA5, 1);
        serve(0, 8'hA5, 10, 0, 0);

        // busy held externally blocks the grant
        tx_busy = 1'b1;
        set_byte(2, 8'h5A);
        req = 4'b0100;
        bad = 0;
        repeat (5) begin
            tick();
            if (grant !== 4'b0 || tx_vld !== 1'b0) bad++;
        end
        check("busy_block", bad, 0);
        tx_busy = 1'b0;
        grant_wait(2, 8'h5A, 1);
        serve(2, 8'h5A, 3, 0, 0);

        // byte captured at grant; REQ dropped and REQ_DATA changed afterwards
        set_byte(1, 8'h3C);
        req = 4'b0010;
        grant_wait(1, 8'h3C, 1);
        serve(1, 8'h3C, 4, 0, 1);

        // reset while in WAIT_DONE
        req_data = '0;
        set_byte(0, 8'h66);
        req = 4'b0001;
        grant_wait(0, 8'h66, 1);
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_grant", grant, 0);
        check("arst_vld", tx_vld, 0);
        check("arst_ack", ack, 0);
        check("arst_data", tx_data, 0);
        check("arst_err", err, 0);
        tx_busy = 1'b0;
        req = '0;
        bad = 0;
        repeat (3) begin
            tick();
            if (ack !== 4'b0 || grant !== 4'b0) bad++;
        end
        check("arst_no_ack", bad, 0);
        rst_n = 1'b1;
        set_byte(1, 8'h71);
        set_byte(3, 8'h73);
        req = 4'b1010;
        grant_wait(1, 8'h71, 1);
        serve(1, 8'h71, 2, 0, 0);
        grant_wait(3, 8'h73, 1);
        serve(3, 8'h73, 2, 0, 0);

        set_byte(0, 8'h81);
        set_byte(1, 8'h82);
        req = 4'b0011;
        grant_wait(0, 8'h81, 1);
`ifdef ARB_TIMEOUT_EN
        bad = 0;
        repeat (15) begin
            tick();
            if (err !== 1'b0) bad++;
        end
        check("err_early", bad, 0);
        tick();
        check("err", err, 1);
        check("err_grant", grant, 0);
        check("err_ack", ack, 0);
        req[0] = 1'b0;
        tick();
        check("err_pulse", err, 0);
        grant_wait(1, 8'h82, 0);
        serve(1, 8'h82, 2, 0, 0);
`else
        bad = 0;
        repeat (30) begin
            tick();
            if (err !== 1'b0 || grant !== 4'b0001) bad++;
        end
        check("no_timeout", bad, 0);
        serve(0, 8'h81, 2, 0, 0);
        grant_wait(1, 8'h82, 1);
        serve(1, 8'h82, 2, 0, 0);
`endif
        req = '0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
